// File: rtl/serial_to_parallel.sv
// LSB-first serial-to-parallel receiver with start-of-frame strobe, one-deep
// valid/ready output buffer, framing-error pulse and sticky overrun flag.
package p2s_pkg;
  localparam int P2S_SERIAL_LEN = 8;
endpackage

module serial_to_parallel
  import p2s_pkg::*;
#(
  parameter int SERIAL_LEN = P2S_SERIAL_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  serial_in,
  input  logic                  sof,
  output logic [SERIAL_LEN-1:0] parallel_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  overrun,
  input  logic                  overrun_clr
);

  localparam int CW = $clog2(SERIAL_LEN);
  localparam logic [CW-1:0] LAST = CW'(SERIAL_LEN - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state;
  logic [SERIAL_LEN-1:0] sr;
  logic [CW-1:0]         cnt;

  logic [SERIAL_LEN-1:0] shifted;
  logic                  complete;
  logic                  accept;

  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    shifted  = {serial_in, sr[SERIAL_LEN-1:1]};
    complete = 1'b0;
    if (state == SHIFT && !sof && cnt == LAST) complete = 1'b1;
    // A word may enter the buffer when it is empty or being drained on this edge.
    accept   = !out_valid || out_ready;
  end

  // NOTE: state registers use non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sr           <= '0;
      cnt          <= '0;
      parallel_out <= '0;
      out_valid    <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      frame_err <= 1'b0;

      case (state)
        IDLE: begin
          if (sof) begin
            sr    <= shifted;
            cnt   <= CW'(1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sr <= shifted;
          if (sof) begin
            // Restart: partial word is abandoned, current bit becomes bit 0.
            frame_err <= 1'b1;
            cnt       <= CW'(1);
          end else if (complete) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase

      if (overrun_clr) overrun <= 1'b0;

      if (complete) begin
        if (accept) begin
          parallel_out <= shifted;
          out_valid    <= 1'b1;
        end else begin
          overrun <= 1'b1;  // later assignment: set beats a simultaneous clear
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: doc/serial_to_parallel.md
# serial_to_parallel

Receive-side counterpart of the parallel-to-serial shifter. Deserialises an LSB-first serial frame of SERIAL_LEN bits, marked by a start-of-frame strobe, into a parallel word. Presents the word on a one-deep valid/ready output buffer. Flags framing errors and overruns. Sits directly on the serial line driven by the shifter; its output feeds the consumer of reconstructed words.

## Interface
- SERIAL_LEN, default P2S_SERIAL_LEN (p2s_pkg), frame/word width in bits; legal range ≥ 2.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- serial_in  in  1  serial data, one bit per clk, LSB first.
- sof  in  1  start of frame; high in the same cycle that bit 0 is on serial_in.
- parallel_out  out  SERIAL_LEN  buffered word; valid while out_valid=1.
- out_valid  out  1  output buffer holds an unconsumed word.
- out_ready  in  1  consumer accepts the word on an edge where out_valid&&out_ready.
- busy  out  1  a frame is being shifted in (state SHIFT).
- frame_err  out  1  one-cycle pulse: sof seen mid-frame.
- overrun  out  1  sticky: completed word was dropped because the buffer was full.
- overrun_clr  in  1  clears overrun.

## Operation
- Datapath:
  - Shift register sr[SERIAL_LEN-1:0] shifts right on each capture: sr <= {serial_in, sr[SERIAL_LEN-1:1]}.
  - Bit counter cnt is $clog2(SERIAL_LEN) bits wide.
  - After SERIAL_LEN captures, bit k of the frame is at sr[k].
- FSM states: IDLE, SHIFT.
  - IDLE, sof=0: no capture; serial_in ignored.
  - IDLE, sof=1: capture bit 0, cnt<=1, go to SHIFT.
  - SHIFT, sof=0: capture, cnt<=cnt+1. When the captured bit is the last (cnt==SERIAL_LEN-1), the word completes and the FSM goes to IDLE.
  - SHIFT, sof=1: frame_err pulses next cycle. The partial word is discarded. The current serial_in bit is captured as bit 0 of a new frame, cnt<=1, FSM stays in SHIFT.
- Word completion: the completed word is {serial_in, sr[SERIAL_LEN-1:1]}. At that edge:
  - Buffer empty, or buffer full with out_ready=1 (handshake on the same edge): load parallel_out, out_valid<=1. No overrun.
  - Buffer full with out_ready=0: new word dropped, parallel_out unchanged, overrun<=1.
- Handshake with no completion on the same edge: out_valid<=0. parallel_out holds its last value, which is don't-care to consumers.
- Overrun flag:
  - overrun_clr=1 clears it.
  - Set and clear on the same edge: set wins.
- busy = (state==SHIFT).

## Timing
- All outputs are registered; none is combinationally driven from inputs.
- Reset values:
  - parallel_out=0, out_valid=0, busy=0, frame_err=0, overrun=0.
  - State IDLE, sr=0, cnt=0.
- Reset mid-frame aborts the frame with no output. The first sof after rst deasserts starts cleanly.
- Latency:
  - sof on edge 0 means the last bit is captured on edge SERIAL_LEN-1.
  - out_valid is high starting the cycle after that edge, i.e. SERIAL_LEN cycles after the sof edge.
- Back-to-back frames: sof may be asserted in the cycle right after the last bit (IDLE at that edge). Sustained throughput is 1 word per SERIAL_LEN cycles with no gaps.
- out_valid stays high until a handshake edge. parallel_out is stable while out_valid=1, except when replaced on a simultaneous handshake+completion edge.
- frame_err is high for exactly one cycle per mid-frame sof.

## Test plan
- Reset, SERIAL_LEN=8, frame 0xA5 (serial bits 1,0,1,0,0,1,0,1), sof on bit 0, out_ready=1 -> out_valid high 8 cycles after sof for exactly one cycle, parallel_out=0xA5, busy high for cycles 1–7, no frame_err/overrun.
- Three back-to-back frames 0x01, 0x80, 0xFF with no gaps, out_ready=1 -> three single-cycle out_valid pulses spaced 8 cycles apart, words in order, no errors.
- Frame 0x3C with out_ready=0, then frame 0xC3 completes while the buffer is full -> parallel_out stays 0x3C, overrun=1. Raise out_ready -> 0x3C is accepted. Pulse overrun_clr -> overrun=0. Repeat with overrun_clr on the completion edge -> overrun=1.
- Buffer holds 0x11 with out_ready=0; raise out_ready on exactly the completion edge of 0x22 -> 0x11 is consumed, out_valid stays 1, parallel_out=0x22, overrun=0.
- sof again at bit 4 of a frame, then a full 0x5A frame from that point -> frame_err pulses once, partial word discarded, parallel_out=0x5A.
- rst asserted at bit 5 of a frame, released, then frame 0x96 -> all outputs 0 during reset, no word from the aborted frame, parallel_out=0x96 afterwards.
